// File: rtl/rv_pkg.sv
// ============================================================================
// Module      : rv_pkg
// Description : Shared types and constants for the prefetching fetch stage:
//               IF/ID register bundle, prefetch FIFO entry and PC step.
// Revision    : 1.0 - initial prefetching fetch stage release
// ============================================================================
`default_nettype none

package rv_pkg;

  localparam int unsigned RV_XLEN    = 64;
  localparam int unsigned RV_ILEN    = 32;
  localparam int unsigned IF_PC_STEP = 4;

  // Instruction handed from IF to ID
  typedef struct packed {
    logic [RV_ILEN-1:0] inst;
    logic [RV_XLEN-1:0] pc;
  } if_id_regs_t;

  // One buffered prefetch word with the PC it was fetched from
  typedef struct packed {
    logic [RV_ILEN-1:0] inst;
    logic [RV_XLEN-1:0] pc;
  } if_pf_entry_t;

endpackage

`default_nettype wire

// File: rtl/if_stage_pf_if.sv
// ============================================================================
// Module      : if_stage_pf_if
// Description : Instruction-memory port: valid/ready request channel and an
//               in-order, non-backpressured response channel.
// Revision    : 1.0 - initial prefetching fetch stage release
// ============================================================================
`default_nettype none

interface if_stage_pf_if #(
  parameter int AW   = 32,
  parameter int ILEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [AW-1:0]   req_addr;
  logic            rsp_valid;
  logic [ILEN-1:0] rsp_data;

  // Fetch stage side
  modport master (
    output req_valid, req_addr,
    input  req_ready, rsp_valid, rsp_data
  );

  // Memory side
  modport slave (
    input  req_valid, req_addr,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

`default_nettype wire

// File: rtl/if_pf_fifo.sv
// ============================================================================
// Module      : if_pf_fifo
// Description : DEPTH-entry synchronous FIFO of prefetched words. Flush
//               dominates push and pop. Head reads as zero when empty.
// Revision    : 1.0 - initial prefetching fetch stage release
// ============================================================================
`default_nettype none

module if_pf_fifo
  import rv_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  wire logic         i_clk,
  input  wire logic         i_rst,
  input  wire logic         i_push,
  input  wire if_pf_entry_t i_data,
  input  wire logic         i_pop,
  input  wire logic         i_flush,
  output if_pf_entry_t      o_head,
  output logic [CW-1:0]     o_count
);

  localparam int PW = $clog2(DEPTH);

  if_pf_entry_t    r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_push;
  logic            w_pop;

  assign w_push = i_push && !i_flush;
  assign w_pop  = i_pop && (r_count != '0) && !i_flush;

  // Pointer and occupancy bookkeeping
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write; contents are don't-care while the slot is not counted
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/if_stage_pf.sv
// ============================================================================
// Module      : if_stage_pf
// Description : Prefetching instruction-fetch stage. Issues sequential
//               fetches under a credit limit, buffers responses in a FIFO
//               and drops responses that were in flight across a redirect.
//               Optional macro IF_PERF_CNT_EN adds saturating performance
//               counters (fetched, dropped, stall cycles).
// Revision    : 1.0 - initial prefetching fetch stage release
// ============================================================================
`default_nettype none

module if_stage_pf
  import rv_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              ILEN     = 32,
  parameter int              AW       = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  wire logic            i_clk,
  input  wire logic            i_rst,
  input  wire logic            i_stall,
  input  wire logic            i_do_branch,
  input  wire logic [XLEN-1:0] i_branch_target,
  if_stage_pf_if.master        imem,
  output logic                 o_valid,
  output if_id_regs_t          o_if_id_regs
`ifdef IF_PERF_CNT_EN
  ,
  output logic [63:0]          o_perf_fetched,
  output logic [63:0]          o_perf_dropped,
  output logic [63:0]          o_perf_stall_cyc
`endif
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_rsp_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_drop_cnt;
  logic [CW-1:0]   w_count;
  logic [CW:0]     w_inflight;
  logic [XLEN-1:0] w_target;
  logic            w_req_valid;
  logic            w_req_fire;
  logic            w_rsp_drop;
  logic            w_push;
  logic            w_pop;
  if_pf_entry_t    w_push_entry;
  if_pf_entry_t    w_head;
  logic            w_unused_bits;

  assign w_target = {i_branch_target[XLEN-1:2], 2'b00};

  // Credits: every issued request already owns a FIFO slot, so responses
  // never need backpressure. No request while in reset or redirecting.
  assign w_inflight  = {1'b0, r_outstanding} + {1'b0, w_count};
  assign w_req_valid = i_rst && !i_do_branch && (w_inflight < (CW+1)'(DEPTH));
  assign w_req_fire  = w_req_valid && imem.req_ready;

  // A response is discarded if it belongs to a pre-redirect stream, including
  // one that lands in the redirect cycle itself.
  assign w_rsp_drop = imem.rsp_valid && (i_do_branch || (r_drop_cnt != '0));
  assign w_push     = imem.rsp_valid && !w_rsp_drop;
  assign w_pop      = o_valid && !i_stall && !i_do_branch;

  assign w_push_entry.inst = RV_ILEN'(imem.rsp_data);
  assign w_push_entry.pc   = RV_XLEN'(r_rsp_pc);

  assign imem.req_valid = w_req_valid;
  assign imem.req_addr  = r_fetch_pc[AW-1:0];

  // Fetch/response PCs, outstanding-request and drop counters
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else if (i_do_branch) begin
      r_fetch_pc    <= w_target;
      r_rsp_pc      <= w_target;
      r_outstanding <= r_outstanding - CW'(imem.rsp_valid);
      r_drop_cnt    <= r_outstanding - CW'(imem.rsp_valid);
    end else begin
      if (w_req_fire) r_fetch_pc <= r_fetch_pc + XLEN'(IF_PC_STEP);
      if (w_push)     r_rsp_pc   <= r_rsp_pc + XLEN'(IF_PC_STEP);
      if (w_rsp_drop) r_drop_cnt <= r_drop_cnt - CW'(1);
      case ({w_req_fire, imem.rsp_valid})
        2'b10:   r_outstanding <= r_outstanding + CW'(1);
        2'b01:   r_outstanding <= r_outstanding - CW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  if_pf_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .i_flush (i_do_branch),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign o_valid           = (w_count != '0);
  assign o_if_id_regs.inst = w_head.inst;
  assign o_if_id_regs.pc   = w_head.pc;

  // Target alignment bits and PC bits above the memory address width
  assign w_unused_bits = ^{i_branch_target[1:0], r_fetch_pc[XLEN-1:AW]};

`ifdef IF_PERF_CNT_EN
  logic [63:0] r_perf_fetched;
  logic [63:0] r_perf_dropped;
  logic [63:0] r_perf_stall_cyc;

  // Saturating event counters
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_perf_fetched   <= '0;
      r_perf_dropped   <= '0;
      r_perf_stall_cyc <= '0;
    end else begin
      if (w_push && (r_perf_fetched != '1))
        r_perf_fetched <= r_perf_fetched + 64'd1;
      if (w_rsp_drop && (r_perf_dropped != '1))
        r_perf_dropped <= r_perf_dropped + 64'd1;
      if (o_valid && i_stall && (r_perf_stall_cyc != '1))
        r_perf_stall_cyc <= r_perf_stall_cyc + 64'd1;
    end
  end

  assign o_perf_fetched   = r_perf_fetched;
  assign o_perf_dropped   = r_perf_dropped;
  assign o_perf_stall_cyc = r_perf_stall_cyc;
`endif

endmodule

`default_nettype wire
